// File: rtl/lb_arbiter_pkg.sv
// Shared types and constants for the two-master local-bus arbiter.
package lb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    localparam logic [1:0] GNT_NONE = 2'b00;

    // Watchdog counter width; at least one bit so a disabled watchdog still elaborates.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/lb_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not granted last wins.
module lb_rr_pick2
    import lb_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = GNT_NONE;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
    end

endmodule

// File: rtl/lb_arbiter.sv
// Shares one local-bus slave port between two masters, one transaction at a time,
// round-robin, with registered downstream requests and a no-ack watchdog.
module lb_arbiter
    import lb_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   m0_waddr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wen,
    output logic                m0_wready,
    input  logic [ADDR_W-1:0]   m0_raddr,
    input  logic                m0_ren,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rvalid,
    output logic                m0_err,

    input  logic [ADDR_W-1:0]   m1_waddr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wen,
    output logic                m1_wready,
    input  logic [ADDR_W-1:0]   m1_raddr,
    input  logic                m1_ren,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rvalid,
    output logic                m1_err,

    output logic [ADDR_W-1:0]   lb_waddr,
    output logic [DATA_W-1:0]   lb_wdata,
    output logic [DATA_W/8-1:0] lb_wstrb,
    output logic                lb_wen,
    input  logic                lb_wready,
    output logic [ADDR_W-1:0]   lb_raddr,
    output logic                lb_ren,
    input  logic [DATA_W-1:0]   lb_rdata,
    input  logic                lb_rvalid,

    output logic [1:0]          gnt
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = cnt_width(TIMEOUT);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [ADDR_W-1:0]   lb_waddr_q, lb_waddr_d;
    logic [DATA_W-1:0]   lb_wdata_q, lb_wdata_d;
    logic [STRB_W-1:0]   lb_wstrb_q, lb_wstrb_d;
    logic                lb_wen_q, lb_wen_d;
    logic [ADDR_W-1:0]   lb_raddr_q, lb_raddr_d;
    logic                lb_ren_q, lb_ren_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]          req;
    logic [1:0]          win;
    logic                win_m1;
    logic                win_wen;
    logic                wack;
    logic                rack;
    logic                timeout_hit;
    logic                wdone;
    logic                rdone;
    logic                tmo_err;

    assign req = {m1_wen | m1_ren, m0_wen | m0_ren};

    lb_rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    assign win_m1  = win[1];
    assign win_wen = win_m1 ? m1_wen : m0_wen;

    // Acks only count while a transaction is outstanding; the ack wins over the watchdog.
    assign wack        = (state_q == WRITE) && lb_wready;
    assign rack        = (state_q == READ) && lb_rvalid;
    assign timeout_hit = (TIMEOUT != 0) && (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT));
    assign wdone       = (state_q == WRITE) && (lb_wready || timeout_hit);
    assign rdone       = (state_q == READ) && (lb_rvalid || timeout_hit);
    assign tmo_err     = timeout_hit && !wack && !rack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            gnt_q      <= GNT_NONE;
            lb_waddr_q <= '0;
            lb_wdata_q <= '0;
            lb_wstrb_q <= '0;
            lb_wen_q   <= 1'b0;
            lb_raddr_q <= '0;
            lb_ren_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            lb_waddr_q <= lb_waddr_d;
            lb_wdata_q <= lb_wdata_d;
            lb_wstrb_q <= lb_wstrb_d;
            lb_wen_q   <= lb_wen_d;
            lb_raddr_q <= lb_raddr_d;
            lb_ren_q   <= lb_ren_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        lb_waddr_d = lb_waddr_q;
        lb_wdata_d = lb_wdata_q;
        lb_wstrb_d = lb_wstrb_q;
        lb_wen_d   = lb_wen_q;
        lb_raddr_d = lb_raddr_q;
        lb_ren_d   = lb_ren_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (win != GNT_NONE) begin
                    gnt_d  = win;
                    last_d = win_m1;
                    cnt_d  = '0;
                    // A master holding both wen and ren is served write-first.
                    if (win_wen) begin
                        state_d    = WRITE;
                        lb_wen_d   = 1'b1;
                        lb_waddr_d = win_m1 ? m1_waddr : m0_waddr;
                        lb_wdata_d = win_m1 ? m1_wdata : m0_wdata;
                        lb_wstrb_d = win_m1 ? m1_wstrb : m0_wstrb;
                    end else begin
                        state_d    = READ;
                        lb_ren_d   = 1'b1;
                        lb_raddr_d = win_m1 ? m1_raddr : m0_raddr;
                    end
                end
            end
            WRITE: begin
                if (wdone) begin
                    state_d  = IDLE;
                    gnt_d    = GNT_NONE;
                    lb_wen_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                if (rdone) begin
                    state_d  = IDLE;
                    gnt_d    = GNT_NONE;
                    lb_ren_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = GNT_NONE;
                lb_wen_d = 1'b0;
                lb_ren_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        m0_wready = gnt_q[0] & wdone;
        m1_wready = gnt_q[1] & wdone;
        m0_rvalid = gnt_q[0] & rdone;
        m1_rvalid = gnt_q[1] & rdone;
        m0_err    = gnt_q[0] & tmo_err;
        m1_err    = gnt_q[1] & tmo_err;
        m0_rdata  = (gnt_q[0] & rack) ? lb_rdata : '0;
        m1_rdata  = (gnt_q[1] & rack) ? lb_rdata : '0;
    end

    assign lb_waddr = lb_waddr_q;
    assign lb_wdata = lb_wdata_q;
    assign lb_wstrb = lb_wstrb_q;
    assign lb_wen   = lb_wen_q;
    assign lb_raddr = lb_raddr_q;
    assign lb_ren   = lb_ren_q;
    assign gnt      = gnt_q;

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed bench for lb_arbiter (TIMEOUT=8) and its round-robin pick sub-module.
module tb_lb_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMEOUT = 8;

    logic clk;
    logic rst;

    logic [ADDR_W-1:0] m0_waddr, m1_waddr, m0_raddr, m1_raddr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
    logic              m0_wen, m1_wen, m0_ren, m1_ren;
    logic              m0_wready, m1_wready, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;

    logic [ADDR_W-1:0] lb_waddr, lb_raddr;
    logic [DATA_W-1:0] lb_wdata, lb_rdata;
    logic [STRB_W-1:0] lb_wstrb;
    logic              lb_wen, lb_ren, lb_wready, lb_rvalid;
    logic [1:0]        gnt;

    logic [1:0]        pk_req, pk_win;
    logic              pk_last;

    int n_tests = 0;
    int n_fail  = 0;

    lb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wen(m0_wen),
        .m0_wready(m0_wready), .m0_raddr(m0_raddr), .m0_ren(m0_ren), .m0_rdata(m0_rdata),
        .m0_rvalid(m0_rvalid), .m0_err(m0_err),
        .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wen(m1_wen),
        .m1_wready(m1_wready), .m1_raddr(m1_raddr), .m1_ren(m1_ren), .m1_rdata(m1_rdata),
        .m1_rvalid(m1_rvalid), .m1_err(m1_err),
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
        .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata),
        .lb_rvalid(lb_rvalid), .gnt(gnt)
    );

    lb_rr_pick2 u_pick_ut (.req(pk_req), .last(pk_last), .win(pk_win));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "bench did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_waddr = '0; m0_wdata = '0; m0_wstrb = '0; m0_wen = 1'b0; m0_raddr = '0; m0_ren = 1'b0;
        m1_waddr = '0; m1_wdata = '0; m1_wstrb = '0; m1_wen = 1'b0; m1_raddr = '0; m1_ren = 1'b0;
        lb_wready = 1'b0; lb_rvalid = 1'b0; lb_rdata = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_pick;
        logic [1:0] reqs [5];
        logic       lasts[5];
        logic [1:0] exps [5];
        reqs  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        lasts = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exps  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 5; i++) begin
            pk_req = reqs[i]; pk_last = lasts[i];
            #1;
            n_tests++;
            if (pk_win !== exps[i]) begin
                n_fail++;
                $display("FAIL pick_%0d: win=%b expected %b (req=%b last=%b)", i, pk_win, exps[i], reqs[i], lasts[i]);
            end
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        #3;
        n_tests++;
        if ({gnt, lb_wen, lb_ren, m0_wready, m1_rvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b wen=%b ren=%b expected all 0", gnt, lb_wen, lb_ren);
        end
        n_tests++;
        if ({lb_waddr, lb_wdata, lb_wstrb, lb_raddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: waddr=%h wdata=%h raddr=%h expected 0", lb_waddr, lb_wdata, lb_raddr);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_write;
        m0_waddr = 16'h0004; m0_wdata = 32'hdeadbeef; m0_wstrb = 4'b1111; m0_wen = 1'b1;
        #1;
        n_tests++;
        if (lb_wen !== 1'b0) begin n_fail++; $display("FAIL wr_early: lb_wen=%b expected 0", lb_wen); end
        tick();
        n_tests++;
        if ({lb_wen, gnt, lb_waddr, lb_wdata, lb_wstrb} !== {1'b1, 2'b01, 16'h0004, 32'hdeadbeef, 4'b1111}) begin
            n_fail++;
            $display("FAIL wr_issue: wen=%b gnt=%b addr=%h data=%h strb=%b expected 1 01 0004 deadbeef 1111",
                     lb_wen, gnt, lb_waddr, lb_wdata, lb_wstrb);
        end
        n_tests++;
        if (m0_wready !== 1'b0) begin n_fail++; $display("FAIL wr_noack0: m0_wready=%b expected 0", m0_wready); end
        tick();
        n_tests++;
        if ({lb_wen, m0_wready} !== 2'b10) begin
            n_fail++; $display("FAIL wr_hold: wen=%b wready=%b expected 1 0", lb_wen, m0_wready);
        end
        lb_wready = 1'b1;
        #1;
        n_tests++;
        if ({m0_wready, m1_wready, m0_err} !== 3'b100) begin
            n_fail++; $display("FAIL wr_ack: m0_wready=%b m1_wready=%b err=%b expected 1 0 0", m0_wready, m1_wready, m0_err);
        end
        tick();
        m0_wen = 1'b0;
        #1;
        n_tests++;
        if ({gnt, lb_wen, m0_wready} !== 4'b0) begin
            n_fail++; $display("FAIL wr_done: gnt=%b wen=%b wready=%b expected 00 0 0", gnt, lb_wen, m0_wready);
        end
        lb_wready = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        m1_raddr = 16'h0010; m1_ren = 1'b1;
        tick();
        n_tests++;
        if ({lb_ren, lb_wen, gnt, lb_raddr} !== {1'b1, 1'b0, 2'b10, 16'h0010}) begin
            n_fail++; $display("FAIL rd_issue: ren=%b wen=%b gnt=%b raddr=%h expected 1 0 10 0010", lb_ren, lb_wen, gnt, lb_raddr);
        end
        lb_rdata = 32'h0ead0eef; lb_rvalid = 1'b1;
        #1;
        n_tests++;
        if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h0ead0eef}) begin
            n_fail++; $display("FAIL rd_ack: m1_rvalid=%b m1_rdata=%h expected 1 0ead0eef", m1_rvalid, m1_rdata);
        end
        n_tests++;
        if ({m0_rvalid, m0_rdata, m1_err} !== '0) begin
            n_fail++; $display("FAIL rd_other: m0_rvalid=%b m0_rdata=%h m1_err=%b expected 0", m0_rvalid, m0_rdata, m1_err);
        end
        tick();
        m1_ren = 1'b0;
        #1;
        n_tests++;
        if ({gnt, lb_ren, m1_rvalid, m1_rdata} !== '0) begin
            n_fail++; $display("FAIL rd_idle_ack: gnt=%b ren=%b m1_rvalid=%b m1_rdata=%h expected 0", gnt, lb_ren, m1_rvalid, m1_rdata);
        end
        lb_rvalid = 1'b0; lb_rdata = '0;
        tick();
    endtask

    task automatic test_contention;
        logic [1:0] exp_gnt;
        do_reset();
        m0_waddr = 16'h0100; m0_wen = 1'b1;
        m1_waddr = 16'h0200; m1_wen = 1'b1;
        lb_wready = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL ct_start: gnt=%b expected 00", gnt); end
        for (int i = 0; i < 6; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            n_tests++;
            if ({gnt, m1_wready, m0_wready} !== {exp_gnt, exp_gnt}) begin
                n_fail++; $display("FAIL ct_grant_%0d: gnt=%b wready=%b%b expected %b", i, gnt, m1_wready, m0_wready, exp_gnt);
            end
            n_tests++;
            if (lb_waddr !== ((i % 2 == 0) ? 16'h0100 : 16'h0200)) begin
                n_fail++; $display("FAIL ct_addr_%0d: lb_waddr=%h", i, lb_waddr);
            end
            tick();
            if (i == 4) m0_wen = 1'b0;
            if (i == 5) m1_wen = 1'b0;
            #1;
            n_tests++;
            if ({gnt, m0_wready, m1_wready} !== 4'b0) begin
                n_fail++; $display("FAIL ct_idle_%0d: gnt=%b wready=%b%b expected 00 0 0", i, gnt, m0_wready, m1_wready);
            end
        end
        tick();
        n_tests++;
        if ({gnt, lb_wen} !== 3'b0) begin n_fail++; $display("FAIL ct_end: gnt=%b wen=%b expected 00 0", gnt, lb_wen); end
        lb_wready = 1'b0;
        tick();
    endtask

    task automatic test_write_read_same;
        m0_waddr = 16'h0030; m0_wdata = 32'h11223344; m0_wstrb = 4'b0101; m0_wen = 1'b1;
        m0_raddr = 16'h0034; m0_ren = 1'b1;
        tick();
        n_tests++;
        if ({gnt, lb_wen, lb_ren} !== 4'b0110) begin
            n_fail++; $display("FAIL wr_first: gnt=%b wen=%b ren=%b expected 01 1 0", gnt, lb_wen, lb_ren);
        end
        lb_wready = 1'b1;
        #1;
        n_tests++;
        if ({m0_wready, m0_rvalid} !== 2'b10) begin
            n_fail++; $display("FAIL wr_first_ack: wready=%b rvalid=%b expected 1 0", m0_wready, m0_rvalid);
        end
        tick();
        m0_wen = 1'b0; lb_wready = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL wr_rd_gap: gnt=%b expected 00", gnt); end
        tick();
        n_tests++;
        if ({gnt, lb_ren, lb_wen, lb_raddr} !== {2'b01, 1'b1, 1'b0, 16'h0034}) begin
            n_fail++; $display("FAIL rd_second: gnt=%b ren=%b wen=%b raddr=%h expected 01 1 0 0034", gnt, lb_ren, lb_wen, lb_raddr);
        end
        lb_rvalid = 1'b1; lb_rdata = 32'h12345678;
        #1;
        n_tests++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h12345678}) begin
            n_fail++; $display("FAIL rd_second_ack: rvalid=%b rdata=%h expected 1 12345678", m0_rvalid, m0_rdata);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        m0_raddr = 16'h0020; m0_ren = 1'b1; lb_rdata = 32'hffffffff;
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            n_tests++;
            if ({lb_ren, m0_rvalid} !== 2'b10) begin
                n_fail++; $display("FAIL to_wait_%0d: ren=%b rvalid=%b expected 1 0", k, lb_ren, m0_rvalid);
            end
            tick();
        end
        n_tests++;
        if ({m0_rvalid, m0_err, m0_rdata, m1_err} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL to_fire: rvalid=%b err=%b rdata=%h m1_err=%b expected 1 1 0 0", m0_rvalid, m0_err, m0_rdata, m1_err);
        end
        tick();
        m0_ren = 1'b0;
        #1;
        n_tests++;
        if ({lb_ren, gnt, m0_err, m0_rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL to_after: ren=%b gnt=%b err=%b rvalid=%b expected 0", lb_ren, gnt, m0_err, m0_rvalid);
        end
        tick();
        m0_ren = 1'b1;
        tick();
        for (int k = 0; k < TIMEOUT; k++) tick();
        lb_rvalid = 1'b1; lb_rdata = 32'ha5a5a5a5;
        #1;
        n_tests++;
        if ({m0_rvalid, m0_err, m0_rdata} !== {1'b1, 1'b0, 32'ha5a5a5a5}) begin
            n_fail++; $display("FAIL to_ack_wins: rvalid=%b err=%b rdata=%h expected 1 0 a5a5a5a5", m0_rvalid, m0_err, m0_rdata);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        m0_raddr = 16'h0040; m0_ren = 1'b1;
        tick();
        n_tests++;
        if (lb_ren !== 1'b1) begin n_fail++; $display("FAIL rm_busy: ren=%b expected 1", lb_ren); end
        lb_rvalid = 1'b1; lb_rdata = 32'hcafef00d;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({lb_ren, gnt, lb_raddr, m0_rvalid, m0_rdata} !== '0) begin
            n_fail++; $display("FAIL rm_abort: ren=%b gnt=%b raddr=%h rvalid=%b rdata=%h expected 0",
                               lb_ren, gnt, lb_raddr, m0_rvalid, m0_rdata);
        end
        clear_inputs();
        tick();
        rst = 1'b1;
        m0_wen = 1'b1; m1_wen = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL rm_first_tie: gnt=%b expected 01", gnt); end
        lb_wready = 1'b1;
        #1;
        n_tests++;
        if ({m0_wready, m1_wready} !== 2'b10) begin
            n_fail++; $display("FAIL rm_ack: m0_wready=%b m1_wready=%b expected 1 0", m0_wready, m1_wready);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        pk_req = 2'b00; pk_last = 1'b0;
        rst = 1'b0;
        test_pick();
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_write_read_same();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
